// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC controller: issues one instruction fetch at a time, resolves the
// next PC from mini-decode flags, and stalls jalr until its base register is readable.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned JW_CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ifu_req_valid,
  input  logic                ifu_req_ready,
  output logic [31:0]         ifu_req_pc,
  input  logic                instr_valid,
  input  logic                isjal,
  input  logic                isjalr,
  input  logic                isbxx,
  input  logic                ismret,
  input  logic                isecall,
  input  logic                predict_bxxtaken,
  input  logic [31:0]         jaloffset,
  input  logic [31:0]         jalroffset,
  input  logic [31:0]         bxxoffset,
  input  logic                jalr_dep,
  input  logic                fet_is_xn,
  input  logic [31:0]         jalr_xn,
  input  logic                dec_rs3_req,
  output logic                rs3_sel,
  input  logic [31:0]         csr_mepc,
  input  logic [31:0]         csr_mtvec,
  input  logic                exe_flush,
  input  logic [31:0]         exe_flush_pc,
  output logic                fetch_stall,
  output logic [JW_CNT_W-1:0] jw_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_JWAIT
  } state_t;

  localparam logic [JW_CNT_W-1:0] JW_ONE = JW_CNT_W'(1);
  localparam logic [JW_CNT_W-1:0] JW_MAX = '1;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [JW_CNT_W-1:0] jw_cnt_q, jw_cnt_d;
  logic                discard_q, discard_d;

  logic                jalr_ready;
  logic [31:0]         jalr_target;
  logic [31:0]         next_pc;
  logic                jalr_blocked;
  logic                handshake;

  // The rs3 port is shared with decode; a base in x2..x31 can only be read
  // when decode is not using the port this cycle.
  assign jalr_ready  = ~jalr_dep & (~fet_is_xn | ~dec_rs3_req);
  assign jalr_target = (jalr_xn + jalroffset) & 32'hFFFF_FFFE;
  assign handshake   = (state_q == S_REQ) & ifu_req_ready;

  // NOTE: every variable written in a combinational block gets a default at
  // the top so that no path leaves it unassigned and a latch is inferred.
  always_comb begin
    next_pc      = pc_q + 32'd4;
    jalr_blocked = 1'b0;
    if (ismret) begin
      next_pc = csr_mepc;
    end else if (isecall) begin
      next_pc = csr_mtvec;
    end else if (isjal) begin
      next_pc = pc_q + jaloffset;
    end else if (isjalr) begin
      next_pc      = jalr_target;
      jalr_blocked = ~jalr_ready;
    end else if (isbxx & predict_bxxtaken) begin
      next_pc = pc_q + bxxoffset;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    jw_cnt_d  = jw_cnt_q;
    discard_d = discard_q & ~instr_valid;

    if (exe_flush) begin
      state_d = S_REQ;
      pc_d    = exe_flush_pc;
      unique case (state_q)
        // The response for the current request is still owed unless it is
        // arriving right now as a genuine (non-stale) response.
        S_RSP:   discard_d = discard_q | ~instr_valid;
        S_REQ:   discard_d = handshake | (discard_q & ~instr_valid);
        default: discard_d = discard_q & ~instr_valid;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
        end
        S_REQ: begin
          if (ifu_req_ready) state_d = S_RSP;
        end
        S_RSP: begin
          if (instr_valid & ~discard_q) begin
            if (jalr_blocked) begin
              state_d  = S_JWAIT;
              jw_cnt_d = JW_ONE;
            end else begin
              state_d = S_REQ;
              pc_d    = next_pc;
            end
          end
        end
        S_JWAIT: begin
          if (jalr_ready) begin
            state_d = S_REQ;
            pc_d    = jalr_target;
          end else if (jw_cnt_q != JW_MAX) begin
            jw_cnt_d = jw_cnt_q + JW_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      jw_cnt_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      jw_cnt_q  <= jw_cnt_d;
      discard_q <= discard_d;
    end
  end

  assign ifu_req_valid = (state_q == S_REQ);
  assign ifu_req_pc    = pc_q;
  assign fetch_stall   = (state_q == S_JWAIT);
  assign jw_cnt        = jw_cnt_q;
  assign rs3_sel       = (((state_q == S_RSP) & instr_valid) | (state_q == S_JWAIT))
                         & isjalr & fet_is_xn & ~dec_rs3_req;

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter JW_CNT_W, default 4, width of the jalr-wait cycle counter.
REQ-003 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  instruction memory accepts request.
- ifu_req_pc  out  32  fetch address.
- instr_valid  in  1  instruction for last accepted request present; mini-decode outputs valid.
- isjal, isjalr, isbxx, ismret, isecall  in  1 each  mini-decode class flags.
- predict_bxxtaken  in  1  static branch prediction (imm sign).
- jaloffset, jalroffset, bxxoffset  in  32 each  sign-extended offsets.
- jalr_dep  in  1  jalr base register written by decode stage.
- fet_is_xn  in  1  jalr base is x2..x31.
- jalr_xn  in  32  jalr base value (x1 or rs3 port).
- dec_rs3_req  in  1  decode stage requests shared rs3 read port.
- rs3_sel  out  1  rs3 port owner: 0 decode, 1 fetch.
- csr_mepc, csr_mtvec  in  32 each  mret / ecall targets.
- exe_flush  in  1  execute-stage redirect (mispredict/trap).
- exe_flush_pc  in  32  redirect target.
- fetch_stall  out  1  fetch holding in jalr wait.
- jw_cnt  out  JW_CNT_W  cycles spent in current/last jalr wait, saturating.

Function
REQ-004 SHALL implement states IDLE, REQ, RSP, JWAIT.
REQ-005 IDLE: first edge after reset release -> REQ with ifu_req_pc=RESET_PC.
REQ-006 REQ: ifu_req_valid=1; ifu_req_pc stable until ifu_req_valid&ifu_req_ready; on handshake -> RSP.
REQ-007 RSP: ifu_req_valid=0; on instr_valid compute next PC, register into ifu_req_pc, -> REQ (one outstanding request only).
REQ-008 Next-PC priority on instr_valid: ismret->csr_mepc; isecall->csr_mtvec; isjal->pc+jaloffset; isjalr (ready per REQ-010)->jalr target; isbxx&predict_bxxtaken->pc+bxxoffset; else pc+4.
REQ-009 pc = ifu_req_pc of accepted request; all adds modulo 2^32; jalr target = (jalr_xn+jalroffset) with bit0 forced 0.
REQ-010 jalr ready = ~jalr_dep & (~fet_is_xn | ~dec_rs3_req); if isjalr&instr_valid and not ready -> JWAIT, instruction fields must be held stable by upstream while fetch_stall=1.
REQ-011 rs3_sel=1 only when (state RSP with instr_valid or state JWAIT) & isjalr & fet_is_xn & ~dec_rs3_req; decode always wins a conflict.
REQ-012 JWAIT: fetch_stall=1, ifu_req_valid=0, jw_cnt increments each cycle saturating at all-ones; on jalr ready -> REQ with jalr target, fetch_stall=0.
REQ-013 jw_cnt cleared on JWAIT entry (entry cycle counts as 1), holds value after exit.
REQ-014 exe_flush has highest priority in every state: ifu_req_pc<=exe_flush_pc, -> REQ, fetch_stall=0; any pending response in RSP is discarded (next instr_valid ignored once).
REQ-015 exe_flush in REQ without handshake replaces address; handshake same cycle still counts as to the old address being dropped.
REQ-016 instr_valid in REQ or JWAIT SHALL be ignored except per REQ-014 discard.

Reset
REQ-017 rst_n low asynchronously: state=IDLE, ifu_req_valid=0, ifu_req_pc=RESET_PC, rs3_sel=0, fetch_stall=0, jw_cnt=0, discard flag=0; reset mid-JWAIT or mid-RSP abandons operation.

Verification
REQ-018 Reset release, ready=1 -> cycle1 valid=1 pc=0x0; instr_valid non-branch -> next pc=0x4.
REQ-019 pc=0x100, isjal, jaloffset=0xFFFFFFF0 -> next ifu_req_pc=0x0F0; isbxx taken bxxoffset=0x20 -> 0x120; not taken -> 0x104.
REQ-020 isjalr, fet_is_xn=1, dec_rs3_req=1 for 3 cycles, jalr_xn=0x2001, jalroffset=0x10 -> fetch_stall 3 cycles, jw_cnt=3, rs3_sel=1 on release, ifu_req_pc=0x2010.
REQ-021 JWAIT with jalr_dep=1 for 20 cycles, JW_CNT_W=4 -> jw_cnt saturates at 15; exe_flush=1, exe_flush_pc=0x8000 mid-wait -> fetch_stall=0, ifu_req_pc=0x8000 next cycle.
REQ-022 ismret with csr_mepc=0x400 -> 0x400; exe_flush in RSP then instr_valid -> response dropped, pc=flush target; rst_n low in RSP -> all outputs reset values immediately.
